// File: rtl/bc_mem_pkg.sv
// bc_mem_pkg: shared types and helpers for the BureCore memory responder.
package bc_mem_pkg;

   // Upper bound on the request-to-response latency.
   localparam int unsigned BC_MEM_MAX_LATENCY = 8;

   // Data width of the standard BureCore memory port.
   localparam int unsigned BC_MEM_DATA_WIDTH = 32;

   // One response beat: read data plus error flag.
   typedef struct packed {
      logic [BC_MEM_DATA_WIDTH-1:0] rdata;
      logic                         err;
   } bc_mem_rsp_t;

   // Index width that stays >= 1 even for a single-entry structure.
   function automatic int unsigned bc_idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bc_rsp_fifo.sv
// bc_rsp_fifo: valid/ready response FIFO. The output is taken straight from the
// head entry, and a push into an empty FIFO is presented in the same cycle.
module bc_rsp_fifo
   import bc_mem_pkg::*;
#(
   parameter int unsigned Depth  = 4,
   parameter type         item_t = bc_mem_rsp_t
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  push_valid_i,
   input  item_t push_data_i,
   output logic  pop_valid_o,
   input  logic  pop_ready_i,
   output item_t pop_data_o
);

   localparam int unsigned PtrW = bc_idx_width(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   item_t           storage [Depth];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            empty;
   logic            wr_en;
   logic            rd_en;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Head selection with empty-bypass; an entry that is bypassed and popped is never stored.
   always_comb begin
      empty       = (count_q == '0);
      pop_valid_o = !empty || push_valid_i;
      pop_data_o  = '0;
      if (!empty) begin
         pop_data_o = storage[rd_ptr_q];
      end else if (push_valid_i) begin
         pop_data_o = push_data_i;
      end
      wr_en = push_valid_i && !(empty && pop_ready_i);
      rd_en = !empty && pop_ready_i;
   end

   // Entry storage; contents need no reset since count_q gates visibility.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         storage[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (rd_en) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_q + CntW'(wr_en) - CntW'(rd_en);
      end
   end

endmodule

// File: rtl/bc_mem_responder.sv
// bc_mem_responder: memory-side responder for the BureCore request/response
// protocol. Word-addressed array, fixed-latency response pipeline, and a
// credit-limited response FIFO so no response is ever dropped.
// Optional macro BC_MEM_RANGE_CHECK_EN: enables RANGE_WORDS address checking;
// otherwise addresses wrap modulo DEPTH_WORDS and o_rsp_err is always 0.
module bc_mem_responder
   import bc_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = BC_MEM_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter int unsigned RSP_DEPTH   = 4
`ifdef BC_MEM_RANGE_CHECK_EN
   ,
   parameter int unsigned RANGE_WORDS = DEPTH_WORDS
`endif
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_we,
   input  logic [ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [DATA_WIDTH/8-1:0] i_req_be,
   input  logic [DATA_WIDTH-1:0]   i_req_wdata,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
   output logic                    o_rsp_err
);

   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned ALSB     = $clog2(BE_WIDTH);
   localparam int unsigned IDX_W    = bc_idx_width(DEPTH_WORDS);
   localparam int unsigned CNT_W    = $clog2(RSP_DEPTH + 1);
   // Stage count clamped to the supported latency range.
   localparam int unsigned PIPE_N   = (LATENCY < 1) ? 1 :
                                      (LATENCY > BC_MEM_MAX_LATENCY) ? BC_MEM_MAX_LATENCY :
                                      LATENCY;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rdata;
      logic                  err;
   } rsp_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
   logic                  accept;
   logic                  rsp_pop;
   logic [IDX_W-1:0]      word_idx;
   logic                  addr_err;
   rsp_t                  rsp_in;
   rsp_t                  rsp_head;
   logic                  pipe_valid_q [PIPE_N];
   rsp_t                  pipe_data_q  [PIPE_N];
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic                  req_ready_q;
   logic                  unused_addr;

   assign accept      = i_req_valid & req_ready_q;
   assign rsp_pop     = o_rsp_valid & i_rsp_ready;
   assign o_req_ready = req_ready_q;
   assign word_idx    = i_req_addr[ALSB +: IDX_W];
   // Low byte-offset bits are intentionally ignored.
   assign unused_addr = ^i_req_addr;

`ifdef BC_MEM_RANGE_CHECK_EN
   localparam int unsigned HI_LSB = ALSB + IDX_W;
   logic idx_out_of_range;
   logic high_bits_set;
   assign idx_out_of_range = 32'(word_idx) >= RANGE_WORDS;
   assign high_bits_set    = (i_req_addr >> HI_LSB) != '0;
   assign addr_err         = idx_out_of_range | high_bits_set;
`else
   assign addr_err = 1'b0;
`endif

   // Byte-masked array write at the accept edge; flagged addresses never write.
   always_ff @(posedge i_clk) begin
      if (accept && i_req_we && !addr_err) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (i_req_be[b]) begin
               mem[word_idx][b*8 +: 8] <= i_req_wdata[b*8 +: 8];
            end
         end
      end
   end

   // Response captured at accept: read data sampled now, zero for writes and errors.
   always_comb begin
      rsp_in     = '0;
      rsp_in.err = addr_err;
      if (!i_req_we && !addr_err) begin
         rsp_in.rdata = mem[word_idx];
      end
   end

   // Fixed-latency shift pipeline feeding the response FIFO.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < PIPE_N; i++) begin
            pipe_valid_q[i] <= 1'b0;
            pipe_data_q[i]  <= '0;
         end
      end else begin
         pipe_valid_q[0] <= accept;
         pipe_data_q[0]  <= rsp_in;
         for (int i = 1; i < PIPE_N; i++) begin
            pipe_valid_q[i] <= pipe_valid_q[i-1];
            pipe_data_q[i]  <= pipe_data_q[i-1];
         end
      end
   end

   // Credit limit guarantees the last stage never meets a full FIFO.
   bc_rsp_fifo #(
      .Depth  (RSP_DEPTH),
      .item_t (rsp_t)
   ) u_rsp_fifo (
      .clk_i        (i_clk),
      .rst_ni       (i_rst_n),
      .push_valid_i (pipe_valid_q[PIPE_N-1]),
      .push_data_i  (pipe_data_q[PIPE_N-1]),
      .pop_valid_o  (o_rsp_valid),
      .pop_ready_i  (i_rsp_ready),
      .pop_data_o   (rsp_head)
   );

   assign o_rsp_rdata = rsp_head.rdata;
   assign o_rsp_err   = rsp_head.err;

   // Outstanding count: +1 on accept, -1 on pop, unchanged when both happen.
   always_comb begin
      cnt_d = cnt_q;
      if (accept && !rsp_pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!accept && rsp_pop) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Counter and registered request-ready, low throughout reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q       <= '0;
         req_ready_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         req_ready_q <= (cnt_d < CNT_W'(RSP_DEPTH));
      end
   end

endmodule

// File: tb/tb_bc_mem_responder.sv
// tb_bc_mem_responder: directed self-checking bench for bc_mem_responder
// (LATENCY=2, RSP_DEPTH=4). Build with BC_MEM_RANGE_CHECK_EN for the range-check variant.
module tb_bc_mem_responder;

   localparam int LAT = 2;
`ifdef BC_MEM_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_cmp  = 0;
   int n_fail = 0;

   bc_mem_responder #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .DEPTH_WORDS (1024),
      .LATENCY     (LAT),
      .RSP_DEPTH   (4)
`ifdef BC_MEM_RANGE_CHECK_EN
      ,
      .RANGE_WORDS (512)
`endif
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_we    (req_we),
      .i_req_addr  (req_addr),
      .i_req_be    (req_be),
      .i_req_wdata (req_wdata),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_rdata (rsp_rdata),
      .o_rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] pat(input int i);
      return 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready);
      end
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
      end
      n_cmp++;
      if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_rsp_data: got rdata=%h err=%b want 0/0", rsp_rdata, rsp_err);
      end
      rst_n = 1'b1;
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_fail++; $display("FAIL release_no_edge_ready: got %b want 0", req_ready);
      end
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_fail++; $display("FAIL first_edge_ready: got %b want 1", req_ready);
      end
   endtask

   // Write/read-after-write plus byte-enable merge and ignored address LSBs.
   task automatic test_basic_rw();
      vec_t v [6];
      bit   want_valid;
      v[0] = '{1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0};
      v[1] = '{1'b0, 32'h10, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0};
      v[2] = '{1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b0};
      v[3] = '{1'b1, 32'h20, 4'h1, 32'h0000_0012, 32'h0,         1'b0};
      v[4] = '{1'b0, 32'h20, 4'h0, 32'h0,         32'hFFFF_FF12, 1'b0};
      v[5] = '{1'b0, 32'h23, 4'h0, 32'h0,         32'hFFFF_FF12, 1'b0};
      rsp_ready = 1'b1;
      for (int c = 0; c <= 6 + LAT; c++) begin
         want_valid = (c >= LAT) && (c < 6 + LAT);
         n_cmp++;
         if (want_valid) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== v[c-LAT].exp_rdata ||
                rsp_err !== v[c-LAT].exp_err) begin
               n_fail++;
               $display("FAIL basic_rw_rsp[%0d]: got valid=%b rdata=%h err=%b want 1/%h/%b",
                        c - LAT, rsp_valid, rsp_rdata, rsp_err, v[c-LAT].exp_rdata,
                        v[c-LAT].exp_err);
            end
         end else if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_rw_idle[%0d]: got valid=%b want 0", c, rsp_valid);
         end
         if (c < 6) begin
            n_cmp++;
            if (req_ready !== 1'b1) begin
               n_fail++; $display("FAIL basic_rw_ready[%0d]: got %b want 1", c, req_ready);
            end
            req_valid = 1'b1;
            req_we    = v[c].we;
            req_addr  = v[c].addr;
            req_be    = v[c].be;
            req_wdata = v[c].wdata;
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      rsp_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         req_valid = 1'b1;
         req_we    = 1'b0;
         req_addr  = (acc % 2 == 0) ? 32'h10 : 32'h20;
         if (req_ready) acc++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      n_cmp++;
      if (acc !== 4) begin
         n_fail++; $display("FAIL bp_accept_count: got %0d want 4", acc);
      end
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_ready_low: got %b want 0", req_ready);
      end
      for (int s = 0; s < 3; s++) begin
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bp_head_stable[%0d]: got valid=%b rdata=%h want 1/deadbeef",
                     s, rsp_valid, rsp_rdata);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (rsp_valid !== 1'b1 ||
             rsp_rdata !== ((k % 2 == 0) ? 32'hDEAD_BEEF : 32'hFFFF_FF12)) begin
            n_fail++;
            $display("FAIL bp_drain[%0d]: got valid=%b rdata=%h", k, rsp_valid, rsp_rdata);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_after_drain: got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_stream();
      logic [31:0] q [$];
      logic [31:0] e;
      int          stalls = 0;
      int          accepted = 0;
      int          popped = 0;
      int          j = 0;
      rsp_ready = 1'b1;
      // 100 writes then 100 reads, one per cycle with ready held high.
      for (int i = 0; i < 200; i++) begin
         if (rsp_valid && rsp_ready) begin
            n_cmp++; popped++;
            e = (q.size() > 0) ? q.pop_front() : 32'hXXXX_XXXX;
            if (rsp_rdata !== e) begin
               n_fail++; $display("FAIL stream_rsp[%0d]: got %h want %h", popped, rsp_rdata, e);
            end
         end
         req_valid = 1'b1;
         req_we    = (i < 100);
         req_addr  = 32'((256 + (i % 100)) * 4);
         req_be    = 4'hF;
         req_wdata = pat(i % 100);
         if (!req_ready) stalls++;
         else begin
            accepted++;
            q.push_back((i < 100) ? 32'h0 : pat(i % 100));
         end
         @(negedge clk);
      end
      n_cmp++;
      if (stalls !== 0) begin
         n_fail++; $display("FAIL stream_back_to_back: got %0d stall cycles want 0", stalls);
      end
      // Random response back-pressure with continuous reads.
      for (int t = 0; t < 1000 && j < 60; t++) begin
         rsp_ready = 1'($urandom_range(0, 1));
         if (rsp_valid && rsp_ready) begin
            n_cmp++; popped++;
            e = (q.size() > 0) ? q.pop_front() : 32'hXXXX_XXXX;
            if (rsp_rdata !== e) begin
               n_fail++; $display("FAIL rand_rsp[%0d]: got %h want %h", popped, rsp_rdata, e);
            end
         end
         req_valid = 1'b1;
         req_we    = 1'b0;
         req_addr  = 32'((256 + ((j * 7) % 100)) * 4);
         if (req_ready) begin
            q.push_back(pat((j * 7) % 100));
            accepted++;
            j++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int t = 0; t < 50; t++) begin
         if (rsp_valid) begin
            n_cmp++; popped++;
            e = (q.size() > 0) ? q.pop_front() : 32'hXXXX_XXXX;
            if (rsp_rdata !== e) begin
               n_fail++; $display("FAIL drain_rsp[%0d]: got %h want %h", popped, rsp_rdata, e);
            end
         end
         @(negedge clk);
      end
      n_cmp++;
      if (j !== 60 || popped !== accepted || q.size() !== 0 || accepted !== 260) begin
         n_fail++;
         $display("FAIL stream_totals: got reads=%0d popped=%0d accepted=%0d left=%0d want 60/260/260/0",
                  j, popped, accepted, q.size());
      end
   endtask

   task automatic test_reset_inflight();
      int seen = 0;
      rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         req_valid = 1'b1;
         req_we    = 1'b0;
         req_addr  = 32'h10;
         @(negedge clk);
      end
      req_valid = 1'b0;
      n_cmp++;
      if (rsp_valid !== 1'b1) begin
         n_fail++; $display("FAIL inflight_before_reset: got valid=%b want 1", rsp_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%b ready=%b rdata=%h want 0/0/0",
                  rsp_valid, req_ready, rsp_rdata);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
      end
      for (int c = 0; c < 6; c++) begin
         if (rsp_valid) seen++;
         @(negedge clk);
      end
      n_cmp++;
      if (seen !== 0) begin
         n_fail++; $display("FAIL stale_response: got %0d responses want 0", seen);
      end
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h10;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL write_persists: got valid=%b rdata=%h want 1/deadbeef", rsp_valid, rsp_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_range();
      vec_t v [7];
      bit   want_valid;
      v[0] = '{1'b1, 32'h40,        4'hF, 32'h0BAD_F00D, 32'h0, 1'b0};
      v[1] = '{1'b1, 32'h160,       4'hF, 32'h8888_8888, 32'h0, 1'b0};
      v[2] = '{1'b1, 32'h960,       4'hF, 32'h600D_600D, 32'h0, RC};
      v[3] = '{1'b1, 32'h8000_0040, 4'hF, 32'h1234_5678, 32'h0, RC};
      v[4] = '{1'b0, 32'h960,       4'h0, 32'h0, RC ? 32'h0 : 32'h600D_600D, RC};
      v[5] = '{1'b0, 32'h160,       4'h0, 32'h0, 32'h8888_8888, 1'b0};
      v[6] = '{1'b0, 32'h40,        4'h0, 32'h0, RC ? 32'h0BAD_F00D : 32'h1234_5678, 1'b0};
      rsp_ready = 1'b1;
      for (int c = 0; c <= 7 + LAT; c++) begin
         want_valid = (c >= LAT) && (c < 7 + LAT);
         n_cmp++;
         if (want_valid) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== v[c-LAT].exp_rdata ||
                rsp_err !== v[c-LAT].exp_err) begin
               n_fail++;
               $display("FAIL range_rsp[%0d]: got valid=%b rdata=%h err=%b want 1/%h/%b",
                        c - LAT, rsp_valid, rsp_rdata, rsp_err, v[c-LAT].exp_rdata,
                        v[c-LAT].exp_err);
            end
         end else if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL range_idle[%0d]: got valid=%b want 0", c, rsp_valid);
         end
         if (c < 7) begin
            req_valid = 1'b1;
            req_we    = v[c].we;
            req_addr  = v[c].addr;
            req_be    = v[c].be;
            req_wdata = v[c].wdata;
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 32'h0;
      req_be    = 4'h0;
      req_wdata = 32'h0;
      rsp_ready = 1'b1;
      test_reset();
      test_basic_rw();
      test_backpressure();
      test_stream();
      test_reset_inflight();
      test_range();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
